// File: rtl/dac_multi_pkg.sv
// Shared types and helpers for the multi-channel DAC: code width limits,
// code-to-voltage scaling and the bounded-rate slew step.
package dac_multi_pkg;

  localparam int MAX_BITS = 24;

  typedef logic [MAX_BITS-1:0] code_t;

  // Channel-index width; a single-channel DAC still carries a 1-bit index.
  function automatic int chan_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic real code_to_real(input code_t code, input int bits,
                                       input real fullscale);
    return real'(code) * fullscale / real'(longint'(1) << bits);
  endfunction

  // Move current toward target by at most step; step = 0 means jump.
  // The difference is formed one bit wider so it never wraps.
  function automatic code_t slew_next(input code_t current, input code_t target,
                                      input int unsigned step);
    logic signed [MAX_BITS:0] diff;
    logic        [MAX_BITS:0] mag;
    diff = $signed({1'b0, target}) - $signed({1'b0, current});
    mag  = (diff < 0) ? $unsigned(-diff) : $unsigned(diff);
    if (step == 0 || 32'(mag) <= step) begin
      return target;
    end else if (diff > 0) begin
      return current + MAX_BITS'(step);
    end else begin
      return current - MAX_BITS'(step);
    end
  endfunction

endpackage

// File: rtl/dac_multi_if.sv
// Write port of the multi-channel DAC: channel/code pairs over valid/ready.
interface dac_multi_if #(
  parameter int CHAN_W = 2,
  parameter int BITS   = 8
);

  logic              wr_valid;
  logic              wr_ready;
  logic [CHAN_W-1:0] wr_chan;
  logic [BITS-1:0]   wr_code;

  modport master (
    output wr_valid,
    output wr_chan,
    output wr_code,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_chan,
    input  wr_code,
    output wr_ready
  );

endinterface

// File: rtl/dac_slew_channel.sv
// One DAC channel: pending/target/current code registers, slew-limited
// tracking of the target and the real-valued output voltage.
module dac_slew_channel
  import dac_multi_pkg::*;
#(
  parameter int          BITS       = 8,
  parameter real         FULLSCALE  = 1.0,
  parameter int unsigned SLEW_STEP  = 16,
  parameter bit          AUTO_LOAD  = 1'b0,
  parameter int          RESET_CODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [BITS-1:0] wr_code,
  input  logic            ldac,
  output logic [BITS-1:0] code_out,
  output logic            busy,
  output real             out_v
);

  localparam logic [BITS-1:0] RST_VAL = BITS'(RESET_CODE);

  logic [BITS-1:0] pending_q, pending_d;
  logic [BITS-1:0] target_q,  target_d;
  logic [BITS-1:0] current_q, current_d;
  code_t           slewed;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pending_d = pending_q;
    target_d  = target_q;
    if (AUTO_LOAD) begin
      if (wr_en) target_d = wr_code;
    end else begin
      // ldac copies the pre-edge pending value; a same-cycle write waits for the next ldac.
      if (ldac)  target_d  = pending_q;
      if (wr_en) pending_d = wr_code;
    end
    // Slew works from the pre-edge target, so a new target moves current one edge later.
    slewed    = slew_next(code_t'(current_q), code_t'(target_q), SLEW_STEP);
    current_d = slewed[BITS-1:0];
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      pending_q <= RST_VAL;
      target_q  <= RST_VAL;
      current_q <= RST_VAL;
    end else begin
      pending_q <= pending_d;
      target_q  <= target_d;
      current_q <= current_d;
    end
  end

  assign code_out = current_q;
  assign busy     = (current_q != target_q);
  assign out_v    = code_to_real(code_t'(current_q), BITS, FULLSCALE);

endmodule

// File: rtl/dac_multi.sv
// Multi-channel double-buffered DAC: decodes writes to channels, flags
// out-of-range channel writes and reduces per-channel busy.
module dac_multi
  import dac_multi_pkg::*;
#(
  parameter int          BITS       = 8,
  parameter int          CHANNELS   = 4,
  parameter real         FULLSCALE  = 1.0,
  parameter int unsigned SLEW_STEP  = 16,
  parameter bit          AUTO_LOAD  = 1'b0,
  parameter int          RESET_CODE = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  dac_multi_if.slave                     wr,
  input  logic                           ldac,
  output logic                           busy,
  output logic                           err,
  output logic [CHANNELS-1:0][BITS-1:0]  code_out,
  output real                            out [CHANNELS]
);

  localparam int CHAN_W = chan_width(CHANNELS);

  logic                accept;
  logic                err_q, err_d;
  logic [CHANNELS-1:0] chan_wr_en;
  logic [CHANNELS-1:0] chan_busy;

  assign wr.wr_ready = ~rst;
  assign accept      = wr.wr_valid & wr.wr_ready;

  // An out-of-range write is still accepted; it only raises the sticky error.
  always_comb begin
    err_d      = err_q;
    chan_wr_en = '0;
    if (accept && 32'(wr.wr_chan) >= CHANNELS) err_d = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      chan_wr_en[c] = accept && (32'(wr.wr_chan) == c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err  = err_q;
  assign busy = |chan_busy;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    dac_slew_channel #(
      .BITS       (BITS),
      .FULLSCALE  (FULLSCALE),
      .SLEW_STEP  (SLEW_STEP),
      .AUTO_LOAD  (AUTO_LOAD),
      .RESET_CODE (RESET_CODE)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (chan_wr_en[c]),
      .wr_code  (wr.wr_code),
      .ldac     (ldac),
      .code_out (code_out[c]),
      .busy     (chan_busy[c]),
      .out_v    (out[c])
    );
  end

  // The index width only matters for synthesis checks on mismatched interfaces.
  logic [CHAN_W-1:0] unused_chan;
  assign unused_chan = wr.wr_chan;

endmodule

// File: tb/tb_dac_multi.sv
// Self-checking bench for dac_multi: directed scenarios plus randomized
// traffic against a per-cycle reference model, and a second configuration.
module tb_dac_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Configuration A: BITS=8, CHANNELS=4, SLEW_STEP=16, AUTO_LOAD=0
  logic                rst_a;
  logic                ldac_a;
  logic                busy_a;
  logic                err_a;
  logic [3:0][7:0]     code_out_a;
  real                 out_a [4];
  dac_multi_if #(.CHAN_W(2), .BITS(8)) wr_a ();

  dac_multi #(
    .BITS(8), .CHANNELS(4), .FULLSCALE(1.0), .SLEW_STEP(16),
    .AUTO_LOAD(1'b0), .RESET_CODE(0)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .wr(wr_a), .ldac(ldac_a), .busy(busy_a),
    .err(err_a), .code_out(code_out_a), .out(out_a)
  );

  // Configuration B: BITS=8, CHANNELS=3, SLEW_STEP=0, AUTO_LOAD=1
  logic                rst_b;
  logic                ldac_b;
  logic                busy_b;
  logic                err_b;
  logic [2:0][7:0]     code_out_b;
  real                 out_b [3];
  dac_multi_if #(.CHAN_W(2), .BITS(8)) wr_b ();

  dac_multi #(
    .BITS(8), .CHANNELS(3), .FULLSCALE(1.0), .SLEW_STEP(0),
    .AUTO_LOAD(1'b1), .RESET_CODE(0)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .wr(wr_b), .ldac(ldac_b), .busy(busy_b),
    .err(err_b), .code_out(code_out_b), .out(out_b)
  );

  // Reference model for configuration A, in plain integer arithmetic.
  int pend [4];
  int tgt  [4];
  int cur  [4];
  bit err_m;

  task automatic chk_i(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_r(input string tag, input real obs, input real exp);
    n_vec++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %f expected %f", tag, obs, exp);
    end
  endtask

  function automatic int slew_ref(input int c, input int t);
    if (t - c > 16)  return c + 16;
    if (c - t > 16)  return c - 16;
    return t;
  endfunction

  task automatic model_step(input bit r, input bit v, input int ch, input int code, input bit ld);
    if (r) begin
      for (int c = 0; c < 4; c++) begin
        pend[c] = 0; tgt[c] = 0; cur[c] = 0;
      end
      err_m = 1'b0;
    end else begin
      for (int c = 0; c < 4; c++) cur[c] = slew_ref(cur[c], tgt[c]);
      if (ld) for (int c = 0; c < 4; c++) tgt[c] = pend[c];
      if (v) begin
        if (ch < 4) pend[ch] = code;
        else        err_m = 1'b1;
      end
    end
  endtask

  task automatic check_all_a();
    bit any_busy;
    any_busy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk_i($sformatf("a_code_out[%0d]", c), code_out_a[c], cur[c]);
      chk_r($sformatf("a_out[%0d]", c), out_a[c], real'(cur[c]) / 256.0);
      if (cur[c] != tgt[c]) any_busy = 1'b1;
    end
    chk_i("a_busy", busy_a, any_busy);
    chk_i("a_err", err_a, err_m);
    chk_i("a_wr_ready", wr_a.wr_ready, !rst_a);
  endtask

  // One clock of configuration A: drive, advance model at the edge, check after it.
  task automatic cyc_a(input bit r, input bit v, input int ch, input int code, input bit ld);
    logic [31:0] ch_v, code_v;
    ch_v = ch; code_v = code;
    rst_a          = r;
    wr_a.wr_valid  = v;
    wr_a.wr_chan   = ch_v[1:0];
    wr_a.wr_code   = code_v[7:0];
    ldac_a         = ld;
    @(posedge clk);
    model_step(r, v, ch, code, ld);
    #1;
    check_all_a();
  endtask

  task automatic cyc_b(input bit r, input bit v, input int ch, input int code, input bit ld);
    logic [31:0] ch_v, code_v;
    ch_v = ch; code_v = code;
    rst_b          = r;
    wr_b.wr_valid  = v;
    wr_b.wr_chan   = ch_v[1:0];
    wr_b.wr_code   = code_v[7:0];
    ldac_b         = ld;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; ldac_a = 1'b0;
    wr_a.wr_valid = 1'b0; wr_a.wr_chan = '0; wr_a.wr_code = '0;
    rst_b = 1'b1; ldac_b = 1'b0;
    wr_b.wr_valid = 1'b0; wr_b.wr_chan = '0; wr_b.wr_code = '0;

    // Reset held three cycles, then released.
    repeat (3) begin
      cyc_a(1, 0, 0, 0, 0);
      chk_i("rst_wr_ready", wr_a.wr_ready, 0);
      chk_r("rst_out2", out_a[2], 0.0);
    end
    rst_a = 1'b0;
    #1;
    chk_i("rel_wr_ready", wr_a.wr_ready, 1);

    // Pending write has no effect until ldac, then a 16-code/cycle ramp.
    cyc_a(0, 1, 2, 128, 0);
    repeat (10) begin
      cyc_a(0, 0, 0, 0, 0);
      chk_r("s2_hold_out2", out_a[2], 0.0);
    end
    cyc_a(0, 0, 0, 0, 1);
    chk_i("s2_busy_after_ldac", busy_a, 1);
    chk_r("s2_no_move_yet", out_a[2], 0.0);
    for (int i = 1; i <= 8; i++) begin
      cyc_a(0, 0, 0, 0, 0);
      chk_r("s2_ramp_out2", out_a[2], 0.0625 * i);
      chk_i("s2_ramp_busy", busy_a, (i < 8) ? 1 : 0);
    end
    chk_r("s2_final_out2", out_a[2], 0.5);

    // Downward retarget 128 -> 100 clamps at the target.
    cyc_a(0, 1, 2, 100, 0);
    cyc_a(0, 0, 0, 0, 1);
    chk_i("s3_code_hold", code_out_a[2], 128);
    cyc_a(0, 0, 0, 0, 0);
    chk_i("s3_code_step", code_out_a[2], 112);
    cyc_a(0, 0, 0, 0, 0);
    chk_i("s3_code_clamp", code_out_a[2], 100);
    chk_i("s3_busy_done", busy_a, 0);

    // Write and ldac in the same cycle: the write waits for the next ldac.
    cyc_a(0, 1, 1, 255, 1);
    repeat (3) begin
      cyc_a(0, 0, 0, 0, 0);
      chk_i("s4_ch1_stays", code_out_a[1], 0);
    end
    cyc_a(0, 0, 0, 0, 1);
    repeat (17) cyc_a(0, 0, 0, 0, 0);
    chk_i("s4_ch1_code", code_out_a[1], 255);
    chk_r("s4_ch1_out", out_a[1], 0.99609375);

    // Reset in the middle of a ramp aborts it and clears pending.
    cyc_a(1, 0, 0, 0, 0);
    cyc_a(0, 1, 2, 128, 0);
    cyc_a(0, 0, 0, 0, 1);
    repeat (3) cyc_a(0, 0, 0, 0, 0);
    chk_i("s5_step3", code_out_a[2], 48);
    cyc_a(1, 1, 2, 200, 1);
    chk_r("s5_rst_out2", out_a[2], 0.0);
    chk_i("s5_rst_busy", busy_a, 0);
    cyc_a(0, 0, 0, 0, 1);
    repeat (3) begin
      cyc_a(0, 0, 0, 0, 0);
      chk_i("s5_ldac_nochange", code_out_a[2], 0);
      chk_i("s5_busy", busy_a, 0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cyc_a(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
            ($urandom_range(0, 5) == 0));
    end

    // Configuration B: out-of-range channel and auto-load with unlimited slew.
    repeat (2) cyc_b(1, 0, 0, 0, 0);
    chk_i("b_rst_err", err_b, 0);
    chk_i("b_rst_ready", wr_b.wr_ready, 0);
    cyc_b(0, 1, 3, 77, 0);
    chk_i("b_err_set", err_b, 1);
    chk_i("b_oor_busy", busy_b, 0);
    for (int c = 0; c < 3; c++) chk_i($sformatf("b_oor_code[%0d]", c), code_out_b[c], 0);
    repeat (3) cyc_b(0, 0, 0, 0, 0);
    chk_i("b_err_sticky", err_b, 1);
    cyc_b(0, 1, 0, 200, 0);
    chk_r("b_out0_lat", out_b[0], 0.0);
    chk_i("b_busy_lat", busy_b, 1);
    cyc_b(0, 0, 0, 0, 0);
    chk_r("b_out0", out_b[0], 0.78125);
    chk_i("b_code0", code_out_b[0], 200);
    chk_i("b_busy_done", busy_b, 0);
    cyc_b(0, 1, 1, 50, 1);
    cyc_b(0, 0, 0, 0, 0);
    chk_i("b_code1_auto", code_out_b[1], 50);
    chk_i("b_err_still", err_b, 1);
    cyc_b(1, 0, 0, 0, 0);
    chk_i("b_err_cleared", err_b, 0);
    chk_i("b_code0_rst", code_out_b[0], 0);
    chk_r("b_out1_rst", out_b[1], 0.0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
